// File: rtl/traffic_density_sensor.sv
// Loop-detector conditioner: synchronises and debounces the raw sensor, counts
// vehicle arrivals per fixed window and drives a hysteresis-filtered traffic flag.
module traffic_density_sensor #(
  parameter int WINDOW = 64,
  parameter int DEB    = 2,
  parameter int CNT_W  = 8,
  parameter int HI_TH  = 5,
  parameter int LO_TH  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor,
  input  logic             enable,
  output logic             traffic,
  output logic [CNT_W-1:0] vehicle_count,
  output logic             window_done
);

  localparam int TW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;

  localparam logic [TW-1:0]    TIMER_LAST = TW'(WINDOW - 1);
  localparam logic [DW-1:0]    DEB_LAST   = DW'(DEB - 1);
  localparam logic [CNT_W-1:0] HI_LVL     = CNT_W'(HI_TH);
  localparam logic [CNT_W-1:0] LO_LVL     = CNT_W'(LO_TH);
  localparam logic [CNT_W-1:0] ACC_MAX    = '1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] EVAL  = 2'd2;

  logic [1:0]       state;
  logic             s1, s2;
  logic             db, db_q;
  logic [DW-1:0]    deb_cnt;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] acc;
  logic             vehicle;

  // Synchroniser and debouncer run continuously, independent of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      db      <= 1'b0;
      db_q    <= 1'b0;
      deb_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so s1->s2 forms a real two-flop chain
      // instead of collapsing into a single flop.
      s1   <= sensor;
      s2   <= s1;
      db_q <= db;
      if (s2 != db) begin
        if (deb_cnt == DEB_LAST) begin
          db      <= s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // One-cycle arrival strobe on the debounced rising edge.
  assign vehicle     = db & ~db_q;
  assign window_done = (state == EVAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      acc           <= '0;
      traffic       <= 1'b0;
      vehicle_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          acc   <= '0;
          if (enable) state <= COUNT;
        end
        COUNT: begin
          if (!enable) begin
            state <= IDLE;
            timer <= '0;
            acc   <= '0;
          end else begin
            timer <= timer + TW'(1);
            if (vehicle && acc != ACC_MAX) acc <= acc + CNT_W'(1);
            if (timer == TIMER_LAST) state <= EVAL;
          end
        end
        EVAL: begin
          vehicle_count <= acc;
          if (acc >= HI_LVL)      traffic <= 1'b1;
          else if (acc <= LO_LVL) traffic <= 1'b0;
          // An arrival during evaluation belongs to the next window.
          acc   <= {{(CNT_W-1){1'b0}}, vehicle};
          timer <= '0;
          state <= enable ? COUNT : IDLE;
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          acc   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_density_sensor.sv
// Scoreboard bench for traffic_density_sensor: each driven window pushes its
// expected count/flag/timing, checked when window_done pulses.
module tb_traffic_density_sensor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sensor;
  logic       enable;
  logic       traffic, traffic_sat;
  logic [7:0] vehicle_count;
  logic [2:0] vehicle_count_sat;
  logic       window_done, window_done_sat;

  always #5 clk = ~clk;

  traffic_density_sensor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sensor        (sensor),
    .enable        (enable),
    .traffic       (traffic),
    .vehicle_count (vehicle_count),
    .window_done   (window_done)
  );

  traffic_density_sensor #(.CNT_W(3)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .sensor        (sensor),
    .enable        (enable),
    .traffic       (traffic_sat),
    .vehicle_count (vehicle_count_sat),
    .window_done   (window_done_sat)
  );

  typedef struct {
    int cyc;
    int cnt;
    int sat;
    bit tr;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_seen = 0;
  int   pushed = 0;
  bit   pending = 0;
  bit   exp_tr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pending) begin
      pending = 0;
      check("vehicle_count", vehicle_count, cur.cnt);
      check("traffic", traffic, cur.tr);
      check("sat_count", vehicle_count_sat, cur.sat);
      check("done_one_cycle", window_done, 0);
    end
    if (window_done) begin
      done_seen++;
      check("done_sat_align", window_done_sat, window_done);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        check("done_cycle", cyc, cur.cyc);
        pending = 1;
      end
    end
  end

  // Called just after the edge that starts a window (timer==0 cycle); spans
  // exactly WINDOW+1 edges and returns just after the next window's first edge.
  task automatic run_window(input int n, input int h, input int l, input int off,
                            input int exp_cnt);
    exp_t x;
    int   used;
    if (exp_cnt >= 5)      exp_tr = 1;
    else if (exp_cnt <= 2) exp_tr = 0;
    x.cyc = cyc + 64;
    x.cnt = exp_cnt;
    x.sat = (exp_cnt > 7) ? 7 : exp_cnt;
    x.tr  = exp_tr;
    sb.push_back(x);
    pushed++;
    used = off + n * (h + l);
    repeat (off) step();
    for (int i = 0; i < n; i++) begin
      sensor = 1'b1;
      repeat (h) step();
      sensor = 1'b0;
      repeat (l) step();
    end
    repeat (65 - used) step();
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    sensor = 1'b0;

    // Reset held while the sensor toggles.
    for (int i = 0; i < 8; i++) begin
      sensor = ~sensor;
      step();
    end
    sensor = 1'b0;
    @(negedge clk);
    check("rst_traffic", traffic, 0);
    check("rst_count", vehicle_count, 0);
    check("rst_done", window_done, 0);
    check("rst_sat_count", vehicle_count_sat, 0);

    step();
    rst_n = 1'b1;
    repeat (200) step();
    check("idle_no_done", done_seen, 0);
    check("idle_traffic", traffic, 0);

    // First window: done must land 65 cycles after enable.
    enable = 1'b1;
    step();
    run_window(10, 1, 3, 0, 0);  // glitch rejection
    run_window(6, 3, 3, 0, 6);   // assert
    run_window(3, 3, 3, 0, 3);   // hold high
    run_window(2, 3, 3, 0, 2);   // fall
    run_window(4, 3, 3, 0, 4);   // hold low
    run_window(10, 3, 3, 0, 10); // saturates at 7 in the narrow instance
    run_window(1, 3, 3, 59, 1);  // rise in timer==WINDOW-1 cycle: counted here
    run_window(1, 3, 2, 60, 0);  // rise in EVAL cycle: counted next window
    run_window(2, 3, 3, 10, 3);  // 1 carried + 2 new
    run_window(6, 3, 3, 0, 6);

    // Abort at timer==30 after 4 vehicles.
    for (int i = 0; i < 4; i++) begin
      sensor = 1'b1;
      repeat (3) step();
      sensor = 1'b0;
      repeat (3) step();
    end
    repeat (6) step();
    enable = 1'b0;
    repeat (80) step();
    check("abort_no_done", done_seen, pushed);
    check("abort_count_hold", vehicle_count, 6);
    check("abort_traffic_hold", traffic, 1);

    enable = 1'b1;
    step();
    run_window(1, 3, 3, 0, 1);   // restarts from acc=0
    run_window(6, 3, 3, 0, 6);
    repeat (10) step();
    check("done_total", done_seen, pushed);
    check("sb_drained", sb.size(), 0);
    check("pre_reset_traffic", traffic, 1);

    // Asynchronous reset mid-window, away from the clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_traffic", traffic, 0);
    check("async_rst_count", vehicle_count, 0);
    check("async_rst_done", window_done, 0);
    repeat (3) step();
    rst_n  = 1'b1;
    enable = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
